// File: rtl/display_pkg.sv
// display_pkg: shared constants and helpers for the scrolling BCD display.
//   - Active-high 7-segment patterns, bit order {a,b,c,d,e,f,g} (bit 6 = a).
//   - pos_width(): width of the window offset, at least 1 bit.
package display_pkg;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_MINUS = 7'b0000001;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Offsets range over 0..nd-win, so nd-win+1 distinct values.
    function automatic int unsigned pos_width(input int unsigned nd, input int unsigned win);
        int unsigned span;
        span = nd - win + 1;
        return (span > 1) ? $clog2(span) : 1;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational BCD nibble to active-high 7-segment pattern.
//   i_nib  [3:0]  BCD digit; values above 9 decode to blank.
//   o_seg  [6:0]  {a,b,c,d,e,f,g}, active-high.
module seg7_decode
    import display_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_nib)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_scroll_display.sv
// bcd_scroll_display: scrollable, time-multiplexed N-digit BCD display with sign.
//   clk, rst        clock; synchronous active-high reset
//   bcd_in, sign_in value captured on load (digit 0 = bcd_in[3:0])
//   load            capture pulse, also returns the window to offset 0
//   scroll_left     window toward more-significant digits (saturating)
//   scroll_right    window toward less-significant digits (saturating)
//   blank_lz        leading-zero blanking enable
//   segments        registered {a..g}, polarity set by ACTIVE_LOW
//   anode_active    registered one-hot anodes; [WIN] is the sign slot
//   window_pos      current window offset; at_left/at_right flag the limits
module bcd_scroll_display
    import display_pkg::*;
#(
    parameter int NUM_DIGITS  = 5,
    parameter int WIN         = 3,
    parameter int REFRESH_DIV = 250000,
    parameter int ACTIVE_LOW  = 1
)
(
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [4*NUM_DIGITS-1:0]                bcd_in,
    input  logic                                   sign_in,
    input  logic                                   load,
    input  logic                                   scroll_left,
    input  logic                                   scroll_right,
    input  logic                                   blank_lz,
    output logic [6:0]                             segments,
    output logic [WIN:0]                           anode_active,
    output logic [pos_width(NUM_DIGITS, WIN)-1:0]  window_pos,
    output logic                                   at_left,
    output logic                                   at_right
);

    localparam int unsigned PW     = pos_width(NUM_DIGITS, WIN);
    localparam int unsigned MAXPOS = NUM_DIGITS - WIN;
    localparam int unsigned CW     = $clog2(REFRESH_DIV);
    localparam int unsigned SW     = $clog2(WIN + 1);
    localparam logic        POL    = (ACTIVE_LOW != 0);

    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic                    r_sign;
    logic [PW-1:0]           r_pos;
    logic [CW-1:0]           r_cnt;
    logic [SW-1:0]           r_slot;
    logic [6:0]              r_seg;
    logic [WIN:0]            r_anode;

    logic [NUM_DIGITS-1:0]   w_zero_from;
    int unsigned             w_idx;
    logic [3:0]              w_nib;
    logic                    w_lz_blank;
    logic [6:0]              w_dec_seg;
    logic [6:0]              w_seg;
    logic [WIN:0]            w_anode;

    // Shadow value and window offset; load outranks scrolling.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow <= '0;
            r_sign   <= 1'b0;
            r_pos    <= '0;
        end else if (load) begin
            r_shadow <= bcd_in;
            r_sign   <= sign_in;
            r_pos    <= '0;
        end else if (scroll_left && !scroll_right && r_pos != PW'(MAXPOS)) begin
            r_pos    <= r_pos + 1'b1;
        end else if (scroll_right && !scroll_left && r_pos != '0) begin
            r_pos    <= r_pos - 1'b1;
        end
    end

    // Refresh divider and slot index; never disturbed by load or scroll.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_slot <= '0;
        end else if (r_cnt == CW'(REFRESH_DIV - 1)) begin
            r_cnt  <= '0;
            r_slot <= (r_slot == SW'(WIN)) ? '0 : r_slot + 1'b1;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    // w_zero_from[i]: every shadow digit at index >= i is zero.
    always_comb begin
        w_idx      = 32'(r_pos) + 32'(r_slot);
        w_nib      = '0;
        w_lz_blank = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            w_zero_from[i] = ((r_shadow >> (4 * i)) == '0);
        end
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (i == w_idx) begin
                w_nib      = r_shadow[4*i +: 4];
                w_lz_blank = blank_lz && (i != 0) && w_zero_from[i];
            end
        end
    end

    seg7_decode u_dec (
        .i_nib (w_nib),
        .o_seg (w_dec_seg)
    );

    always_comb begin
        w_seg   = SEG_BLANK;
        w_anode = '0;
        for (int unsigned k = 0; k <= WIN; k++) begin
            w_anode[k] = (32'(r_slot) == k);
        end
        if (32'(r_slot) == WIN) begin
            w_seg = r_sign ? SEG_MINUS : SEG_BLANK;
        end else if (!w_lz_blank) begin
            w_seg = w_dec_seg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg   <= {7{POL}};
            r_anode <= {(WIN+1){POL}};
        end else begin
            r_seg   <= w_seg ^ {7{POL}};
            r_anode <= w_anode ^ {(WIN+1){POL}};
        end
    end

    assign segments     = r_seg;
    assign anode_active = r_anode;
    assign window_pos   = r_pos;
    assign at_left      = (r_pos == PW'(MAXPOS));
    assign at_right     = (r_pos == '0);

endmodule
